// File: rtl/task_slot.sv
// Per-task scheduler slot: decodes bus ops, tracks lifecycle, hit budget and priority.
// Optional priority aging is enabled by defining TASK_SLOT_AGING_EN.
module task_slot #(
  parameter int TASK_ID      = 7,
  parameter int ID_W         = 4,
  parameter int PRIO_W       = 4,
  parameter int HIT_W        = 8,
  parameter int HIT_INIT     = 128,
  parameter int AGING_PERIOD = 10000
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     op_valid,
  input  logic [ID_W+7:0]          in_op,
  output logic [ID_W+PRIO_W-1:0]   out_sorter,
  output logic                     out_valid,
  output logic [2:0]               out_state,
  output logic [HIT_W-1:0]         exe_hit
);

  localparam logic [ID_W-1:0] MY_ID = ID_W'(TASK_ID);
  localparam logic [ID_W-1:0] BCAST = '1;

  if (TASK_ID == (1 << ID_W) - 1 || AGING_PERIOD < 1) begin : g_bad_param
    $error("task_slot: TASK_ID collides with broadcast or AGING_PERIOD < 1");
  end

  typedef enum logic [2:0] {
    ST_READY = 3'd0,
    ST_SUSP  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RUN   = 3'd3,
    ST_TERM  = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [PRIO_W-1:0]        base_q, base_d;
  logic [HIT_W-1:0]         hit_q, hit_d;
  logic [PRIO_W-1:0]        boost_d;
  logic [ID_W+PRIO_W-1:0]   sorter_q;
  logic                     valid_q;
  logic [PRIO_W:0]          prio_sum;
  logic [PRIO_W-1:0]        eff_d;

  logic [ID_W-1:0] op_target;
  logic [3:0]      op_code;
  logic [3:0]      op_arg;
  logic            op_hit;
  logic            alive;

  always_comb begin
    op_target = in_op[ID_W+7:8];
    op_code   = in_op[7:4];
    op_arg    = in_op[3:0];
    op_hit    = op_valid && ((op_target == MY_ID) ||
                             ((op_target == BCAST) &&
                              (op_code inside {4'h1, 4'h2, 4'h4, 4'hC})));
    alive     = (state_q != ST_TERM);
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    hit_d   = hit_q;
    if (op_hit && alive) begin
      unique case (op_code)
        4'h1: if (state_q == ST_SUSP || state_q == ST_WAIT) state_d = ST_READY;
        4'h2: if (state_q != ST_SUSP) state_d = ST_SUSP;
        4'h3: if (state_q == ST_READY || state_q == ST_RUN) state_d = ST_WAIT;
        4'h4, 4'hC: state_d = ST_TERM;
        4'h5: base_d = PRIO_W'(op_arg);
        4'h6: hit_d = HIT_W'(op_arg);
        4'h7: begin
          if (state_q == ST_READY && hit_q != '0) begin
            hit_d   = hit_q - 1'b1;
            state_d = ST_RUN;
          end
        end
        4'h8: if (state_q == ST_RUN) state_d = (hit_q == '0) ? ST_TERM : ST_READY;
        default: ;
      endcase
    end
  end

`ifdef TASK_SLOT_AGING_EN
  logic [PRIO_W-1:0] boost_q;
  logic [31:0]       age_q, age_d;
  logic              op_clr;

  // Set priority and Execute restart aging and win over a coincident tick.
  assign op_clr = op_hit && alive &&
                  ((op_code == 4'h5) ||
                   (op_code == 4'h7 && state_q == ST_READY && hit_q != '0));

  always_comb begin
    boost_d = boost_q;
    age_d   = age_q;
    if (op_clr) begin
      boost_d = '0;
      age_d   = '0;
    end else if (state_q == ST_RUN) begin
      age_d = '0;
    end else if (state_q == ST_READY) begin
      if (age_q == 32'(AGING_PERIOD - 1)) begin
        age_d = '0;
        if (boost_q != '1) boost_d = boost_q + 1'b1;
      end else begin
        age_d = age_q + 32'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      boost_q <= '0;
      age_q   <= '0;
    end else begin
      boost_q <= boost_d;
      age_q   <= age_d;
    end
  end
`else
  assign boost_d = '0;
`endif

  always_comb begin
    prio_sum = {1'b0, base_d} + {1'b0, boost_d};
    eff_d    = prio_sum[PRIO_W] ? '1 : prio_sum[PRIO_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= ST_READY;
      base_q   <= '0;
      hit_q    <= HIT_W'(HIT_INIT);
      sorter_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      hit_q    <= hit_d;
      valid_q  <= (state_d == ST_READY);
      sorter_q <= (state_d == ST_READY) ? {MY_ID, eff_d} : '0;
    end
  end

  assign out_sorter = sorter_q;
  assign out_valid  = valid_q;
  assign out_state  = state_q;
  assign exe_hit    = hit_q;

endmodule
